// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// the datapath mux / ALU select codes driven by the controller.
package multicycle_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_ADDIWB = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RDATA2 = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request is stalled; flags a timeout on
// the cycle the count would reach TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic busy,
  input  logic ready,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          waiting;

  assign waiting = busy & ~ready;
  assign timeout = waiting && (cnt == CW'(TIMEOUT - 1));

  // Held at zero outside a stall, so every memory state is entered with a clean count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         cnt <= '0;
    else if (!waiting) cnt <= '0;
    else if (!timeout) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: Moore outputs per state, with IR/PC loads in
// FETCH qualified by mem_ready, and a memory-stall watchdog that halts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int OP_BITS     = 6
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [OP_BITS-1:0] opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic               mem_err,
  output logic [3:0]         state
);
  localparam logic [OP_BITS-1:0] OPC_R    = OP_BITS'(OP_R);
  localparam logic [OP_BITS-1:0] OPC_LW   = OP_BITS'(OP_LW);
  localparam logic [OP_BITS-1:0] OPC_SW   = OP_BITS'(OP_SW);
  localparam logic [OP_BITS-1:0] OPC_ADDI = OP_BITS'(OP_ADDI);
  localparam logic [OP_BITS-1:0] OPC_BEQ  = OP_BITS'(OP_BEQ);
  localparam logic [OP_BITS-1:0] OPC_J    = OP_BITS'(OP_J);

  state_t             state_q, state_n;
  logic [OP_BITS-1:0] op_q;
  logic               legal, timeout;

  assign legal = opcode inside {OPC_R, OPC_LW, OPC_SW, OPC_ADDI, OPC_BEQ, OPC_J};
  assign state = state_q;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .busy    (mem_req),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  // MEMADR is shared by LW/SW/ADDI, so the opcode seen in DECODE is kept.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                   op_q <= '0;
    else if (state_q == S_DECODE) op_q <= opcode;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        mem_err <= 1'b0;
    else if (timeout) mem_err <= 1'b1;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FETCH:  if (timeout) state_n = S_HALT;
                else if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_FETCH;
        if (opcode == OPC_LW || opcode == OPC_SW || opcode == OPC_ADDI) state_n = S_MEMADR;
        else if (opcode == OPC_R)   state_n = S_EXEC;
        else if (opcode == OPC_BEQ) state_n = S_BRANCH;
        else if (opcode == OPC_J)   state_n = S_JUMP;
      end
      S_MEMADR: begin
        if (op_q == OPC_LW)      state_n = S_MEMRD;
        else if (op_q == OPC_SW) state_n = S_MEMWR;
        else                     state_n = S_ADDIWB;
      end
      S_MEMRD:  if (timeout) state_n = S_HALT;
                else if (mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (timeout) state_n = S_HALT;
                else if (mem_ready) state_n = S_FETCH;
      S_EXEC:   state_n = S_RWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RDATA2;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = ~legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = PC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model
// (state path per opcode, random wait states) checked every cycle.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic err_exp = 1'b0;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op, mem_err;
  } ctl_t;

  always #5 Clock = ~Clock;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .OP_BITS(6)) dut (
    .Clock(Clock), .Reset(Reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  endfunction

  // Control values each state must present; anything not named stays 0.
  function automatic ctl_t model(input state_t st, input logic rdy, input logic illeg);
    ctl_t c;
    c = '0;
    c.mem_err = err_exp;
    case (st)
      S_FETCH:  begin c.mem_req = 1; c.alu_src_b = 2'd1; c.ir_write = rdy; c.pc_write = rdy; end
      S_DECODE: begin c.alu_src_b = 2'd3; c.illegal_op = illeg; end
      S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'd2; end
      S_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
      S_MEMWR:  begin c.mem_req = 1; c.iord = 1; c.mem_we = 1; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'd2; end
      S_RWB:    begin c.reg_write = 1; c.reg_dst = 1; end
      S_ADDIWB: c.reg_write = 1;
      S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'd1; c.pc_src = 2'd1; c.pc_write_cond = 1; end
      S_JUMP:   begin c.pc_src = 2'd2; c.pc_write = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  task automatic check_now(input state_t st, input logic illeg, input string tag);
    ctl_t e, o;
    e = model(st, mem_ready, illeg);
    o = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write, reg_dst,
         mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, mem_err};
    n_cmp++;
    assert (state === st) else begin
      n_fail++;
      $error("FAIL %s state: got %0d want %0d", tag, state, st);
    end
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s ctl (state %0d): got %h want %h", tag, st, o, e);
    end
    n_cmp++;
    assert ((reg_write & mem_we) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s rw_we_excl: got %b want 0", tag, reg_write & mem_we);
    end
  endtask

  task automatic step(input state_t st, input logic rdy, input logic [5:0] op,
                      input logic illeg, input string tag);
    @(negedge Clock);
    mem_ready = rdy;
    opcode    = op;
    #1;
    check_now(st, illeg, tag);
  endtask

  // Memory state: w stall cycles then completion; w<0 picks a random stall.
  task automatic mem_phase(input state_t st, input int w, input string tag);
    int n;
    n = w;
    if (n < 0) n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
    repeat (n) step(st, 1'b0, 6'($urandom), 1'b0, tag);
    step(st, 1'b1, 6'($urandom), 1'b0, tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
    state_t path[$];
    mem_phase(S_FETCH, fw, tag);
    step(S_DECODE, 1'($urandom), op, !is_legal(op), tag);
    case (op)
      OP_LW:   path = '{S_MEMADR, S_MEMRD, S_MEMWB};
      OP_SW:   path = '{S_MEMADR, S_MEMWR};
      OP_R:    path = '{S_EXEC, S_RWB};
      OP_ADDI: path = '{S_MEMADR, S_ADDIWB};
      OP_BEQ:  path = '{S_BRANCH};
      OP_J:    path = '{S_JUMP};
      default: path = {};
    endcase
    foreach (path[i]) begin
      if (path[i] == S_MEMRD || path[i] == S_MEMWR) mem_phase(path[i], mw, tag);
      else step(path[i], 1'($urandom), 6'($urandom), 1'b0, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};

    Reset = 1'b1; mem_ready = 1'b0; opcode = '0;
    #3 check_now(S_FETCH, 1'b0, "reset");
    @(negedge Clock); Reset = 1'b0;
    step(S_FETCH, 1'b0, 6'h00, 1'b0, "first_edge");

    run_instr(OP_LW,   0, 0,  "lw");
    run_instr(OP_SW,   0, 3,  "sw_wait3");
    run_instr(OP_BEQ,  0, 0,  "beq");
    run_instr(6'h3f,   0, 0,  "illegal");
    run_instr(OP_R,    0, 0,  "rtype");
    run_instr(OP_ADDI, 0, 0,  "addi");
    run_instr(OP_J,    14, 0, "fetch_wait14");
    run_instr(OP_LW,   2, 14, "memrd_wait14");

    repeat (40) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else op = ops[$urandom_range(0, 5)];
      run_instr(op, -1, -1, "random");
    end

    repeat (15) step(S_FETCH, 1'b0, 6'($urandom), 1'b0, "timeout_wait");
    err_exp = 1'b1;
    repeat (3) step(S_HALT, 1'($urandom), 6'($urandom), 1'b0, "halt");
    #2 Reset = 1'b1; mem_ready = 1'b0; err_exp = 1'b0;
    #1 check_now(S_FETCH, 1'b0, "halt_reset");
    @(negedge Clock); Reset = 1'b0;
    run_instr(OP_R, 0, 0, "after_halt");

    step(S_FETCH, 1'b1, 6'($urandom), 1'b0, "rst_mid");
    step(S_DECODE, 1'b1, OP_LW, 1'b0, "rst_mid");
    step(S_MEMADR, 1'b1, 6'($urandom), 1'b0, "rst_mid");
    step(S_MEMRD, 1'b0, 6'($urandom), 1'b0, "rst_mid");
    #2 Reset = 1'b1; mem_ready = 1'b0;
    #1 check_now(S_FETCH, 1'b0, "rst_memrd");
    @(negedge Clock); Reset = 1'b0;
    run_instr(OP_SW, 0, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles a memory request may wait for mem_ready.
REQ-002 Parameter OP_BITS, default 6, opcode and funct width.
REQ-003 Clock  in  1  single clock; all state updates on posedge Clock.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  OP_BITS  instruction[31:26]; sampled in DECODE.
REQ-006 mem_ready  in  1  memory completes the current request this cycle.
REQ-007 mem_req / mem_we  out  1 / 1  memory request; write qualifier.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 ir_write / pc_write / pc_write_cond  out  1 each  IR load; unconditional PC load; PC load if zero.
REQ-010 reg_write  out  1  register-file write enable.
REQ-011 reg_dst / mem_to_reg  out  1 / 1  write address rd (1) or rt (0); write data from MDR (1) or ALU (0).
REQ-012 alu_src_a  out  1  0 = PC, 1 = rdata1.
REQ-013 alu_src_b  out  2  0 = rdata2, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2.
REQ-014 alu_op  out  2  0 = add, 1 = sub, 2 = decode funct.
REQ-015 pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
REQ-016 illegal_op / mem_err  out  1 / 1  one-cycle illegal-opcode pulse; sticky timeout flag.
REQ-017 state  out  4  current state encoding, for debug.

Function
REQ-018 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDIWB, BRANCH, JUMP, HALT; controller is a Moore machine, except that pc_write and ir_write are qualified by mem_ready.
REQ-019 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0; when mem_ready=1, pulse ir_write and pc_write for that cycle and go to DECODE; otherwise stay in FETCH.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0; next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 001000 -> MEMADR (ADDI path); 000100 -> BRANCH; 000010 -> JUMP; any other opcode -> FETCH, with illegal_op=1 for one cycle.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0; next state MEMRD for LW, MEMWR for SW, ADDIWB for ADDI.
REQ-022 MEMRD / MEMWR: mem_req=1, iord=1, mem_we=1 in MEMWR only; hold the state until mem_ready; then go MEMRD -> MEMWB, MEMWR -> FETCH.
REQ-023 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 for exactly one cycle; then FETCH.
REQ-024 EXEC: alu_src_a=1, alu_src_b=0, alu_op=2; then RWB; RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
REQ-025 ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write_cond=1; then FETCH. JUMP: pc_src=2, pc_write=1; then FETCH.
REQ-027 Every control output not listed for a state SHALL be 0 in that state.
REQ-028 Instruction latency: R/ADDI/SW 4 cycles, LW 5, BEQ/J 3, each with zero wait states; every cycle in which mem_ready=0 extends latency by one.
REQ-029 A wait counter SHALL clear on entry to any memory state and increment each cycle mem_req=1 with mem_ready=0; on reaching MEM_TIMEOUT, set mem_err and enter HALT.
REQ-030 HALT: all control outputs 0, mem_err held at 1; only Reset exits HALT.
REQ-031 reg_write and mem_we SHALL never both be 1 in the same cycle.

Reset
REQ-032 Reset=1 forces state=FETCH, wait counter=0, mem_err=0 and illegal_op=0 immediately, including mid-instruction or mid-request.
REQ-033 On the first Clock edge after Reset deasserts, the controller is in FETCH with mem_req=1.

Structure
REQ-034 Shared package: state enum, opcode constants (R, LW, SW, ADDI, BEQ, J), alu_op/alu_src_b/pc_src encodings; width macros from config.sv.
REQ-035 Sub-module mem_wait_timer (counter + timeout compare) instantiated once; next-state logic and output decode in separate always blocks.

Verification
REQ-036 LW (opcode 100011), mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 in cycle 5 only, with mem_to_reg=1.
REQ-037 SW with mem_ready low for 3 cycles in MEMWR -> mem_req and mem_we held for 4 cycles; reg_write never asserted.
REQ-038 BEQ -> pc_write_cond=1, alu_op=1 in cycle 3; next cycle is FETCH.
REQ-039 Opcode 111111 -> illegal_op pulses for 1 cycle in DECODE, then FETCH.
REQ-040 mem_ready held 0 in FETCH -> mem_err=1 after 15 wait cycles, then HALT; Reset pulse -> FETCH with mem_err=0.
REQ-041 Reset asserted during MEMRD -> state=FETCH and all outputs are at FETCH values before the next Clock edge.
